// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade/PWM stage: default widths and the
// per-channel fade state encoding.
package led_fade_pkg;

    localparam int NUM_LEDS_DEF   = 4;
    localparam int PWM_BITS_DEF   = 8;
    localparam int STEP_COUNT_DEF = 24414;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_HOLD = 2'd2,
        ST_FALL = 2'd3
    } fade_state_t;

endpackage

// File: rtl/led_fade_channel.sv
// One fade channel: brightness level that walks one step per tick toward its
// target, a registered status state, and the registered PWM compare.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int g_PWM_BITS = PWM_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [g_PWM_BITS-1:0] pwm_count,
    input  logic [g_PWM_BITS-1:0] target,
    output logic [g_PWM_BITS-1:0] level,
    output fade_state_t           state,
    output logic                  pwm
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
            state <= ST_OFF;
            pwm   <= 1'b0;
        end else begin
            // Strict compare: level 0 is always dark, full scale misses one slot.
            pwm <= (pwm_count < level);

            if (level < target) begin
                state <= ST_RISE;
            end else if (level > target) begin
                state <= ST_FALL;
            end else if (target == '0) begin
                state <= ST_OFF;
            end else begin
                state <= ST_HOLD;
            end

            // A single step toward the target can never wrap the level.
            if (tick) begin
                if (level < target) begin
                    level <= level + g_PWM_BITS'(1);
                end else if (level > target) begin
                    level <= level - g_PWM_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_fade_pwm.sv
// LED soft-fade PWM driver: registers the blink levels, runs the shared step
// prescaler and PWM counter, and fans out to one fade channel per LED.
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int g_NUM_LEDS   = NUM_LEDS_DEF,
    parameter int g_PWM_BITS   = PWM_BITS_DEF,
    parameter int g_STEP_COUNT = STEP_COUNT_DEF
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst_L,
    input  logic [g_NUM_LEDS-1:0]            i_LED,
    input  logic [g_PWM_BITS-1:0]            i_Max_Level,
    output logic [g_NUM_LEDS-1:0]            o_LED,
    output logic [g_NUM_LEDS*g_PWM_BITS-1:0] o_Level,
    output logic [2*g_NUM_LEDS-1:0]          o_State
);

    localparam int PRESCALE_BITS = (g_STEP_COUNT > 1) ? $clog2(g_STEP_COUNT) : 1;
    localparam logic [PRESCALE_BITS-1:0] PRESCALE_LAST = PRESCALE_BITS'(g_STEP_COUNT - 1);

    logic [PRESCALE_BITS-1:0] prescale_count;
    logic                     step_tick;
    logic [g_PWM_BITS-1:0]    pwm_count;
    logic [g_NUM_LEDS-1:0]    r_led;
    fade_state_t              ch_state [g_NUM_LEDS];

    assign step_tick = (prescale_count == PRESCALE_LAST);

    // Same clock domain as the blink source, so one register stage suffices.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            prescale_count <= '0;
            pwm_count      <= '0;
            r_led          <= '0;
        end else begin
            prescale_count <= step_tick ? '0 : prescale_count + PRESCALE_BITS'(1);
            pwm_count      <= pwm_count + g_PWM_BITS'(1);
            r_led          <= i_LED;
        end
    end

    for (genvar n = 0; n < g_NUM_LEDS; n++) begin : g_ch
        logic [g_PWM_BITS-1:0] target;

        assign target = r_led[n] ? i_Max_Level : '0;

        led_fade_channel #(
            .g_PWM_BITS (g_PWM_BITS)
        ) u_channel (
            .clk       (i_Clk),
            .rst_n     (i_Rst_L),
            .tick      (step_tick),
            .pwm_count (pwm_count),
            .target    (target),
            .level     (o_Level[n*g_PWM_BITS +: g_PWM_BITS]),
            .state     (ch_state[n]),
            .pwm       (o_LED[n])
        );

        assign o_State[2*n +: 2] = ch_state[n];
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: a cycle-level reference model predicts outputs into
// a queue, and a monitor on the falling edge compares them with the DUT.
module tb_led_fade_pwm;
    import led_fade_pkg::*;

    localparam int NUM  = 4;
    localparam int PW   = 4;
    localparam int STEP = 4;
    localparam int PER  = 1 << PW;
    localparam int EW   = NUM + NUM*PW + 2*NUM;

    logic              clk;
    logic              rst_n;
    logic [NUM-1:0]    led;
    logic [PW-1:0]     max_level;
    logic [NUM-1:0]    dut_led;
    logic [NUM*PW-1:0] dut_level;
    logic [2*NUM-1:0]  dut_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];

    led_fade_pwm #(
        .g_NUM_LEDS   (NUM),
        .g_PWM_BITS   (PW),
        .g_STEP_COUNT (STEP)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_LED       (led),
        .i_Max_Level (max_level),
        .o_LED       (dut_led),
        .o_Level     (dut_level),
        .o_State     (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: m_e counts clock edges since the last reset edge.
    // Before edge e the prescaler holds (e-1)%STEP and the PWM counter (e-1)%PER,
    // so a level step happens on every edge where e is a multiple of STEP.
    int             m_e;
    int             m_level[NUM];
    logic [NUM-1:0] m_r;

    always @(posedge clk) begin
        logic [NUM-1:0]    e_led;
        logic [NUM*PW-1:0] e_level;
        logic [2*NUM-1:0]  e_state;
        int                tgt;
        e_led   = '0;
        e_level = '0;
        e_state = '0;
        if (!rst_n) begin
            m_e = 0;
            m_r = '0;
            for (int n = 0; n < NUM; n++) m_level[n] = 0;
        end else begin
            m_e++;
            for (int n = 0; n < NUM; n++) begin
                tgt = m_r[n] ? int'(max_level) : 0;
                if (m_level[n] < tgt)       e_state[2*n +: 2] = ST_RISE;
                else if (m_level[n] > tgt)  e_state[2*n +: 2] = ST_FALL;
                else if (tgt == 0)          e_state[2*n +: 2] = ST_OFF;
                else                        e_state[2*n +: 2] = ST_HOLD;
                e_led[n] = (((m_e - 1) % PER) < m_level[n]);
                if (m_e % STEP == 0) begin
                    if (m_level[n] < tgt)      m_level[n] = m_level[n] + 1;
                    else if (m_level[n] > tgt) m_level[n] = m_level[n] - 1;
                end
            end
            m_r = led;
            for (int n = 0; n < NUM; n++) e_level[PW*n +: PW] = PW'(m_level[n]);
        end
        exp_q.push_back({e_led, e_level, e_state});
    end

    // monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("o_LED", 32'(dut_led), 32'(e[EW-1 -: NUM]));
            check("level", 32'(dut_level), 32'(e[2*NUM +: NUM*PW]));
            check("state", 32'(dut_state), 32'(e[2*NUM-1:0]));
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_level(input int ch, input int value, input string name);
        for (int i = 0; i < 200 && m_level[ch] != value; i++) @(negedge clk);
        if (m_level[ch] != value) check(name, 32'(m_level[ch]), 32'(value));
    endtask

    function automatic logic [PW-1:0] lvl(input int ch);
        return dut_level[PW*ch +: PW];
    endfunction

    function automatic logic [1:0] st(input int ch);
        return dut_state[2*ch +: 2];
    endfunction

    initial begin
        rst_n     = 1'b0;
        led       = 4'hF;
        max_level = 4'd15;
        cycles(3);
        check("reset_o_LED", 32'(dut_led), 0);
        check("reset_level", 32'(dut_level), 0);
        check("reset_state", 32'(dut_state), 0);

        // First step arrives STEP cycles after release.
        rst_n = 1'b1;
        cycles(3);
        check("first_tick_early", 32'(dut_level), 0);
        cycles(1);
        check("first_tick", 32'(dut_level), 32'h1111);

        led = 4'h0;
        cycles(10);

        // Ramp up on channel 0 only.
        led = 4'h1;
        cycles(70);
        check("ramp_level0", 32'(lvl(0)), 15);
        check("ramp_state0", 32'(st(0)), 32'(ST_HOLD));
        check("ramp_others", 32'(dut_level[NUM*PW-1:PW]), 0);
        check("ramp_others_st", 32'(dut_state[2*NUM-1:2]), 0);

        // Reversal of channel 1 at level 6.
        led = 4'h3;
        wait_level(1, 6, "wait_l1_6");
        led = 4'h1;
        cycles(40);
        check("reverse_level1", 32'(lvl(1)), 0);
        check("reverse_state1", 32'(st(1)), 32'(ST_OFF));

        // Ceiling lowered, then raised.
        max_level = 4'd8;
        cycles(40);
        check("ceil_down_level", 32'(lvl(0)), 8);
        check("ceil_down_state", 32'(st(0)), 32'(ST_HOLD));
        max_level = 4'd12;
        cycles(25);
        check("ceil_up_level", 32'(lvl(0)), 12);

        // Zero ceiling: everything decays and stays dark.
        max_level = 4'd0;
        led       = 4'hF;
        cycles(60);
        check("max0_level", 32'(dut_level), 0);
        check("max0_state", 32'(dut_state), 0);
        cycles(20);

        // Reset in the middle of a ramp.
        max_level = 4'd15;
        wait_level(0, 7, "wait_l0_7");
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        check("midreset_level", 32'(dut_level), 0);
        check("midreset_o_LED", 32'(dut_led), 0);
        check("midreset_state", 32'(dut_state), 0);
        cycles(3);
        check("midreset_presc", 32'(dut_level), 0);
        cycles(1);
        check("midreset_tick", 32'(dut_level), 32'h1111);

        // Randomized traffic.
        repeat (250) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                cycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            led = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) max_level = 4'd0;
            else                           max_level = 4'($urandom_range(0, 15));
            cycles($urandom_range(1, 30));
        end

        cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
